// File: rtl/fetch_sequencer_pkg.sv
// Shared state encoding and instruction constants for the fetch sequencer.
// PAUSE is always encoded; it is only reachable with FETCH_SEQUENCER_SINGLE_STEP_EN.
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      FsIdle  = 3'd0,
      FsFetch = 3'd1,
      FsExec  = 3'd2,
      FsHalt  = 3'd3,
      FsFault = 3'd4,
      FsPause = 3'd5
   } fs_state_e;

   localparam logic [6:0]  OPCODE_SYSTEM = 7'b1110011;
   localparam logic [31:0] INSTR_ECALL   = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK  = 32'h0010_0073;

   localparam int unsigned WDOG_W = 8;

   function automatic logic is_halt_instr(input logic [31:0] word);
      return (word[6:0] == OPCODE_SYSTEM) && ((word == INSTR_ECALL) || (word == INSTR_EBREAK));
   endfunction

endpackage

// File: rtl/fetch_sequencer_watchdog.sv
// Saturating 8-bit fetch watchdog. expired is raised on the counting cycle whose
// increment brings the count to TIMEOUT_CYCLES, so the FSM can leave on that edge.
module fetch_watchdog
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam logic [WDOG_W-1:0] Limit = WDOG_W'(TIMEOUT_CYCLES - 1);

   logic [WDOG_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && (count_q != {WDOG_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = count_en && (count_q >= Limit);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/commit controller owning the architectural PC.
// Optional single-step mode (step port, PAUSE state): FETCH_SEQUENCER_SINGLE_STEP_EN.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
   input  logic        step,
`endif
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic [31:0] pc_next_in,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic        halted,
   output logic        fault
);

   fs_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        wd_clear, wd_count_en, wd_expired;

   fetch_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear    (wd_clear),
      .count_en (wd_count_en),
      .expired  (wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      wd_clear    = 1'b1;
      wd_count_en = 1'b0;
      case (state_q)
         FsIdle: begin
            if (run) state_d = FsFetch;
         end
         FsFetch: begin
            wd_clear = 1'b0;
            // An ack on the expiry edge still wins.
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = FsExec;
            end else begin
               wd_count_en = 1'b1;
               if (wd_expired) state_d = FsFault;
            end
         end
         FsExec: begin
            if (is_halt_instr(instr_q)) begin
               state_d = FsHalt;
            end else if (pc_next_in[1:0] != 2'b00) begin
               state_d = FsFault;
            end else begin
               pc_d = pc_next_in;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
               state_d = FsPause;
`else
               state_d = FsFetch;
`endif
            end
         end
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
         FsPause: begin
            if (step) state_d = FsFetch;
         end
`endif
         FsHalt:  state_d = FsHalt;
         FsFault: state_d = FsFault;
         default: state_d = FsIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FsIdle;
         pc_q    <= RESET_PC;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign imem_req    = (state_q == FsFetch);
   assign instr_valid = (state_q == FsExec);
   assign halted      = (state_q == FsHalt);
   assign fault       = (state_q == FsFault);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a per-instruction
// transaction model; honours FETCH_SEQUENCER_SINGLE_STEP_EN.
module tb_fetch_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          TMO    = 4;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam int          MAXN   = 16;

   logic        clk = 1'b0;
   logic        reset, run, imem_ack;
   logic [31:0] imem_rdata, pc_next_in;
   logic        imem_req, instr_valid, halted, fault;
   logic [31:0] imem_addr, instr, pc;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
   logic        step = 1'b0;
`endif

   int checks  = 0;
   int errors  = 0;
   int commits = 0;

   logic [31:0] word [MAXN];
   logic [31:0] tgt  [MAXN];
   int          lat  [MAXN];
   int          prog_n;

   always #5 clk = ~clk;

   always @(negedge clk) if (instr_valid === 1'b1) commits++;

   fetch_sequencer #(
      .RESET_PC       (RST_PC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
      .step        (step),
`endif
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .pc_next_in  (pc_next_in),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .halted      (halted),
      .fault       (fault)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0; pc_next_in = '0;
      tick();
      reset = 1'b0;
      check_eq("rst_req", {31'b0, imem_req}, 32'd0);
      check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("rst_halted", {31'b0, halted}, 32'd0);
      check_eq("rst_fault", {31'b0, fault}, 32'd0);
      check_eq("rst_pc", pc, RST_PC);
      check_eq("rst_instr", instr, 32'd0);
   endtask

   // Runs the program in word/tgt/lat and checks it instruction by instruction.
   task automatic run_episode();
      logic [31:0] exp_pc;
      int          exp_commits, base;
      bit          done, acked, exp_halt;
      do_reset();
      base = commits; exp_pc = RST_PC; exp_commits = 0; done = 0; exp_halt = 0;
      run = 1'b1;
      tick();
      run = 1'($urandom_range(0, 1));
      for (int k = 0; k < prog_n && !done; k++) begin
         acked = 0;
         for (int c = 0; c < TMO && !acked; c++) begin
            check_eq("fetch_req", {31'b0, imem_req}, 32'd1);
            check_eq("fetch_addr", imem_addr, exp_pc);
            imem_ack   = (c == lat[k]);
            imem_rdata = imem_ack ? word[k] : $urandom;
            pc_next_in = tgt[k];
            tick();
            acked = (c == lat[k]);
            run = 1'b0;
         end
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         if (!acked) begin
            check_eq("tmo_fault", {31'b0, fault}, 32'd1);
            check_eq("tmo_pc", pc, exp_pc);
            check_eq("tmo_valid", {31'b0, instr_valid}, 32'd0);
            done = 1;
         end else begin
            check_eq("exec_valid", {31'b0, instr_valid}, 32'd1);
            check_eq("exec_instr", instr, word[k]);
            check_eq("exec_pc", pc, exp_pc);
            check_eq("exec_req", {31'b0, imem_req}, 32'd0);
            exp_commits++;
            tick();
            imem_ack = 1'b0;
            if (word[k] == ECALL || word[k] == EBREAK) begin
               check_eq("halt", {31'b0, halted}, 32'd1);
               check_eq("halt_pc", pc, exp_pc);
               exp_halt = 1; done = 1;
            end else if (tgt[k][1:0] != 2'b00) begin
               check_eq("mis_fault", {31'b0, fault}, 32'd1);
               check_eq("mis_pc", pc, exp_pc);
               done = 1;
            end else begin
               exp_pc = tgt[k];
               check_eq("next_pc", pc, exp_pc);
               check_eq("one_commit", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
               check_eq("pause_req", {31'b0, imem_req}, 32'd0);
               repeat ($urandom_range(0, 2)) begin
                  tick();
                  check_eq("pause_hold", {31'b0, imem_req}, 32'd0);
               end
               step = 1'b1;
               tick();
               step = 1'b0;
`endif
            end
         end
      end
      // Terminal states ignore run and stray acks.
      run = 1'b1; imem_ack = 1'b1;
      repeat (3) tick();
      run = 1'b0; imem_ack = 1'b0;
      check_eq("term_halted", {31'b0, halted}, {31'b0, exp_halt});
      check_eq("term_fault", {31'b0, fault}, {31'b0, !exp_halt});
      check_eq("term_req", {31'b0, imem_req}, 32'd0);
      check_eq("term_pc", pc, exp_pc);
      check_eq("commit_count", 32'(commits - base), 32'(exp_commits));
   endtask

   task automatic gen_random();
      logic [31:0] gpc;
      int          r;
      gpc = RST_PC;
      prog_n = $urandom_range(3, 8);
      for (int k = 0; k < prog_n; k++) begin
         r = $urandom_range(0, 9);
         lat[k] = (r < 8) ? $urandom_range(0, TMO - 1) : TMO + $urandom_range(0, 1);
         word[k] = $urandom;
         if (word[k] == ECALL || word[k] == EBREAK) word[k] = word[k] ^ 32'h100;
         r = $urandom_range(0, 19);
         if (r == 0 || k == prog_n - 1) word[k] = r[0] ? ECALL : EBREAK;
         r = $urandom_range(0, 19);
         if (r < 2)       tgt[k] = gpc + 32'd2;
         else if (r < 7)  tgt[k] = {$urandom_range(0, 32'h3fff_ffff) , 2'b00};
         else             tgt[k] = gpc + 32'd4;
         if (tgt[k][1:0] == 2'b00) gpc = tgt[k];
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed %0d expected %0d", 1, 0);
      $fatal(1, "simulation time limit");
   end

   initial begin
      // Zero-wait addi, addi, ECALL
      prog_n = 3;
      word[0] = 32'h0010_0093; word[1] = 32'h0020_8113; word[2] = ECALL;
      for (int k = 0; k < 3; k++) begin
         lat[k] = 0;
         tgt[k] = 32'(4 * (k + 1));
      end
      run_episode();
      // Three wait cycles per fetch: ack lands on the expiry edge
      for (int k = 0; k < 3; k++) lat[k] = TMO - 1;
      run_episode();
      // No ack at all
      prog_n = 1; lat[0] = TMO + 2; word[0] = 32'h0000_0013;
      run_episode();
      // Misaligned target
      lat[0] = 1; tgt[0] = 32'h0000_0102;
      run_episode();

      // Reset mid-FETCH followed by a late ack
      begin
         int base;
         do_reset();
         base = commits;
         run = 1'b1;
         tick();
         run = 1'b0;
         check_eq("mid_req", {31'b0, imem_req}, 32'd1);
         reset = 1'b1;
         tick();
         reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hdead_beef;
         tick();
         imem_ack = 1'b0;
         check_eq("late_req", {31'b0, imem_req}, 32'd0);
         check_eq("late_instr", instr, 32'd0);
         check_eq("late_pc", pc, RST_PC);
         check_eq("late_commits", 32'(commits - base), 32'd0);
      end

      for (int e = 0; e < 30; e++) begin
         gen_random();
         run_episode();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
